// File: rtl/io_bus_bridge.sv
// io_bus_bridge: splits CPU data-port traffic between DRAM and on-chip peripherals
// (LEDs, seven-segment scanner, synchronised switches/buttons, prescaled timer).
`default_nettype none

module io_bus_bridge #(
  parameter int          DRAM_AW  = 16,
  parameter int          SCAN_DIV = 20000,
  parameter logic [31:0] IO_BASE  = 32'hFFFF_F000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        bus_addr,
  input  logic               bus_we,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw_in,
  input  logic [4:0]         btn_in,
  output logic [23:0]        led_out,
  output logic [7:0]         dig_en,
  output logic [7:0]         seg_out
);

  localparam logic [11:0] c_OFF_DIGITS = 12'h000;
  localparam logic [11:0] c_OFF_TCNT   = 12'h020;
  localparam logic [11:0] c_OFF_TPRE   = 12'h024;
  localparam logic [11:0] c_OFF_LED    = 12'h060;
  localparam logic [11:0] c_OFF_SW     = 12'h070;
  localparam logic [11:0] c_OFF_BTN    = 12'h078;

  localparam int              c_SCW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_SCW-1:0] c_SCAN_LAST = c_SCW'(SCAN_DIV - 1);

  logic        w_io_sel;
  logic [11:0] w_off;
  logic        w_io_we;
  logic        w_wr_digits, w_wr_tcnt, w_wr_tpre, w_wr_led;
  logic        w_tick;
  logic [31:0] w_io_rdata;
  logic [3:0]  w_nibble;

  logic [31:0]      r_digits;
  logic [31:0]      r_tcnt;
  logic [31:0]      r_tpre;
  logic [31:0]      r_pc;
  logic [23:0]      r_led;
  logic [23:0]      r_sw_s1, r_sw_s2;
  logic [4:0]       r_btn_s1, r_btn_s2;
  logic [c_SCW-1:0] r_scan_cnt;
  logic [2:0]       r_scan_idx;

  assign w_io_sel = (bus_addr[31:12] == IO_BASE[31:12]);
  assign w_off    = bus_addr[11:0];
  assign w_io_we  = bus_we & w_io_sel;

  assign w_wr_digits = w_io_we && (w_off == c_OFF_DIGITS);
  assign w_wr_tcnt   = w_io_we && (w_off == c_OFF_TCNT);
  assign w_wr_tpre   = w_io_we && (w_off == c_OFF_TPRE);
  assign w_wr_led    = w_io_we && (w_off == c_OFF_LED);

  assign dram_addr  = bus_addr[DRAM_AW+1:2];
  assign dram_we    = bus_we & ~w_io_sel;
  assign dram_wdata = bus_wdata;

  always_comb begin
    w_io_rdata = 32'h0;
    case (w_off)
      c_OFF_DIGITS: w_io_rdata = r_digits;
      c_OFF_TCNT:   w_io_rdata = r_tcnt;
      c_OFF_TPRE:   w_io_rdata = r_tpre;
      c_OFF_LED:    w_io_rdata = {8'h00, r_led};
      c_OFF_SW:     w_io_rdata = {8'h00, r_sw_s2};
      c_OFF_BTN:    w_io_rdata = {27'h0, r_btn_s2};
      default:      w_io_rdata = 32'h0;
    endcase
  end

  assign bus_rdata = w_io_sel ? w_io_rdata : dram_rdata;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_digits <= '0;
      r_led    <= '0;
    end else begin
      if (w_wr_digits) r_digits <= bus_wdata;
      if (w_wr_led)    r_led    <= bus_wdata[23:0];
    end
  end

  // A store to TCNT overrides the tick; only a TPRE store restarts the prescaler.
  assign w_tick = (r_pc == r_tpre);

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_tcnt <= '0;
      r_tpre <= '0;
      r_pc   <= '0;
    end else begin
      if (w_wr_tpre) begin
        r_tpre <= bus_wdata;
        r_pc   <= '0;
      end else if (w_tick) begin
        r_pc <= '0;
      end else begin
        r_pc <= r_pc + 32'd1;
      end
      if (w_wr_tcnt)   r_tcnt <= bus_wdata;
      else if (w_tick) r_tcnt <= r_tcnt + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= btn_in;
      r_btn_s2 <= r_btn_s1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == c_SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

  assign w_nibble = r_digits[{r_scan_idx, 2'b00} +: 4];
  assign seg_out  = glyph(w_nibble);
  assign dig_en   = ~(8'h01 << r_scan_idx);
  assign led_out  = r_led;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_bridge.sv
// tb_io_bus_bridge: directed plus random stimulus against a behavioural model of the bridge.
`default_nettype none

module tb_io_bus_bridge;

  localparam int          SCAN_DIV = 4;
  localparam logic [31:0] IO       = 32'hFFFF_F000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] bus_addr = '0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic [15:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw_in = '0;
  logic [4:0]  btn_in = '0;
  logic [23:0] led_out;
  logic [7:0]  dig_en;
  logic [7:0]  seg_out;

  int errors = 0;
  int checks = 0;

  io_bus_bridge #(.DRAM_AW(16), .SCAN_DIV(SCAN_DIV), .IO_BASE(IO)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out), .dig_en(dig_en), .seg_out(seg_out)
  );

  always #5 cpu_clk = ~cpu_clk;

  // DRAM stand-in: read data is a fixed pattern of the word address.
  assign dram_rdata = ~{dram_addr, dram_addr};

  logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [31:0] m_digits, m_tcnt, m_tpre, m_pc;
  logic [23:0] m_led, m_sw1, m_sw2;
  logic [4:0]  m_btn1, m_btn2;
  int unsigned m_n;

  function automatic bit is_io(logic [31:0] a);
    return a[31:12] == 20'hFFFFF;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [15:0] w;
    w = a[17:2];
    if (!is_io(a)) return ~{w, w};
    case (a[11:0])
      12'h000: return m_digits;
      12'h020: return m_tcnt;
      12'h024: return m_tpre;
      12'h060: return {8'h00, m_led};
      12'h070: return {8'h00, m_sw2};
      12'h078: return {27'h0, m_btn2};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int m_idx();
    return (m_n / SCAN_DIV) % 8;
  endfunction

  task automatic model_reset();
    m_digits = 0; m_tcnt = 0; m_tpre = 0; m_pc = 0; m_led = 0;
    m_sw1 = 0; m_sw2 = 0; m_btn1 = 0; m_btn2 = 0; m_n = 0;
  endtask

  // One clock edge of the reference: ticks first, stores after, so stores win.
  task automatic model_edge(logic [31:0] a, logic we, logic [31:0] wd);
    bit tick;
    tick = (m_pc == m_tpre);
    m_sw2 = m_sw1;  m_sw1 = sw_in;
    m_btn2 = m_btn1; m_btn1 = btn_in;
    m_n++;
    m_pc = tick ? 32'h0 : m_pc + 1;
    if (tick) m_tcnt = m_tcnt + 1;
    if (we && is_io(a)) begin
      case (a[11:0])
        12'h000: m_digits = wd;
        12'h020: m_tcnt = wd;
        12'h024: begin m_tpre = wd; m_pc = 0; end
        12'h060: m_led = wd[23:0];
        default: ;
      endcase
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_cycle(logic [31:0] a, logic we, logic [31:0] wd);
    logic [7:0] idx;
    bus_addr = a; bus_we = we; bus_wdata = wd;
    #1;
    idx = 8'(m_idx());
    chk("rdata",   bus_rdata, m_read(a));
    chk("dram_we", {31'h0, dram_we}, {31'h0, we & ~is_io(a)});
    chk("dram_addr", {16'h0, dram_addr}, {16'h0, a[17:2]});
    chk("dram_wdata", dram_wdata, wd);
    chk("led_out", {8'h0, led_out}, {8'h0, m_led});
    chk("dig_en",  {24'h0, dig_en}, {24'h0, ~(8'h01 << idx)});
    chk("seg_out", {24'h0, seg_out}, {24'h0, GLYPH[(m_digits >> (4 * idx)) & 32'hF]});
    @(posedge cpu_clk);
    model_edge(a, we, wd);
    #1;
    bus_we = 1'b0;
  endtask

  task automatic peek(logic [31:0] a, logic [31:0] exp, string tag);
    bus_addr = a; bus_we = 1'b0;
    #1;
    chk(tag, bus_rdata, exp);
  endtask

  task automatic do_reset();
    cpu_rst = 1'b0;
    bus_we = 1'b0;
    model_reset();
    #1;
    chk("rst_led", {8'h0, led_out}, 32'h0);
    chk("rst_dig", {24'h0, dig_en}, 32'hFE);
    chk("rst_seg", {24'h0, seg_out}, 32'hC0);
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic        we;
    logic [11:0] offs [8] = '{12'h000, 12'h020, 12'h024, 12'h060,
                              12'h070, 12'h078, 12'h004, 12'h7FC};

    do_reset();
    peek(IO + 32'h020, 32'h0, "rst_tcnt");
    peek(IO + 32'h060, 32'h0, "rst_led_rd");

    // Prescaled timer
    bus_cycle(IO + 32'h024, 1'b1, 32'd3);
    bus_cycle(IO + 32'h020, 1'b1, 32'd0);
    repeat (20) bus_cycle(IO + 32'h070, 1'b0, 32'h0);
    peek(IO + 32'h020, 32'd5, "tcnt_pre3");

    // Wrap and write-over-tick
    bus_cycle(IO + 32'h024, 1'b1, 32'd0);
    bus_cycle(IO + 32'h020, 1'b1, 32'hFFFF_FFFF);
    bus_cycle(IO + 32'h020, 1'b0, 32'h0);
    peek(IO + 32'h020, 32'h0, "tcnt_wrap");
    bus_cycle(IO + 32'h020, 1'b1, 32'h1234);
    peek(IO + 32'h020, 32'h1234, "tcnt_wr_tick");

    // LED
    bus_cycle(IO + 32'h060, 1'b1, 32'h00AB_CDEF);
    chk("led_val", {8'h0, led_out}, 32'h00AB_CDEF);
    peek(IO + 32'h060, 32'h00AB_CDEF, "led_rd");

    // Switch synchroniser latency
    sw_in = 24'h00F00F;
    bus_cycle(IO + 32'h070, 1'b0, 32'h0);
    peek(IO + 32'h070, 32'h0, "sw_edge1");
    bus_cycle(IO + 32'h070, 1'b0, 32'h0);
    peek(IO + 32'h070, 32'h00F00F, "sw_edge2");
    btn_in = 5'h15;
    bus_cycle(IO + 32'h078, 1'b0, 32'h0);
    bus_cycle(IO + 32'h078, 1'b0, 32'h0);
    peek(IO + 32'h078, 32'h15, "btn_edge2");

    // Display scan
    do_reset();
    bus_cycle(IO + 32'h000, 1'b1, 32'h1234_5678);
    chk("scan0_dig", {24'h0, dig_en}, 32'hFE);
    chk("scan0_seg", {24'h0, seg_out}, 32'h80);
    repeat (3) bus_cycle(IO + 32'h004, 1'b0, 32'h0);
    chk("scan1_dig", {24'h0, dig_en}, 32'hFD);
    chk("scan1_seg", {24'h0, seg_out}, 32'hF8);
    repeat (28) bus_cycle(IO + 32'h000, 1'b0, 32'h0);
    chk("scan8_dig", {24'h0, dig_en}, 32'hFE);
    chk("scan8_seg", {24'h0, seg_out}, 32'h80);

    // DRAM pass-through
    bus_addr = 32'h0000_0104; bus_we = 1'b1; bus_wdata = 32'h55;
    #1;
    chk("dram_we_st", {31'h0, dram_we}, 32'h1);
    chk("dram_addr_st", {16'h0, dram_addr}, 32'h41);
    bus_cycle(32'h0000_0104, 1'b1, 32'h55);
    peek(32'h0000_0104, 32'hFFBE_FFBE, "dram_rd");

    // Reset mid-scan
    bus_cycle(IO + 32'h060, 1'b1, 32'h0012_3456);
    repeat (5) bus_cycle(IO + 32'h000, 1'b0, 32'h0);
    do_reset();
    peek(IO + 32'h000, 32'h0, "rst_digits");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) a = {1'b0, 31'($urandom)};
      else a = IO | {20'h0, offs[$urandom_range(0, 7)]};
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == IO + 32'h024) wd = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) sw_in = 24'($urandom);
      if ($urandom_range(0, 7) == 0) btn_in = 5'($urandom);
      bus_cycle(a, we, wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
